// File: rtl/mem_ctrl_arb.sv
// Two-port arbiter onto a narrow asynchronous-read RAM: instruction fetch (read-only) and
// data memory (read/write). Each port word is moved as BEATS RAM accesses, MSB slice first.
module mem_ctrl_arb #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned RAM_W  = 16,
  parameter int unsigned ADDR_W = 17,
  parameter int unsigned BEAT_W = 1,
  parameter int unsigned FAIR   = 0
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     if_req,
  input  logic [ADDR_W-1:0]        if_addr,
  output logic                     if_ack,
  output logic                     if_valid,
  output logic [DATA_W-1:0]        if_rdata,
  input  logic                     mem_req,
  input  logic                     mem_we,
  input  logic [ADDR_W-1:0]        mem_addr,
  input  logic [DATA_W-1:0]        mem_wdata,
  output logic                     mem_ack,
  output logic                     mem_valid,
  output logic [DATA_W-1:0]        mem_rdata,
  output logic [ADDR_W+BEAT_W-1:0] ram_addr,
  output logic                     ram_we,
  output logic [RAM_W-1:0]         ram_wdata,
  input  logic [RAM_W-1:0]         ram_rdata
);

  localparam int unsigned BEATS = 1 << BEAT_W;

  typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

  state_e                     state_q, state_d;
  logic [BEAT_W-1:0]          beat_q;
  logic [ADDR_W-1:0]          lat_addr_q;
  logic                       lat_we_q;
  logic [DATA_W-1:0]          lat_wdata_q;
  logic                       lat_mem_q;
  logic                       last_mem_q;
  logic [DATA_W-1:0]          buf_q;
  logic [DATA_W-1:0]          buf_d;
  logic [DATA_W-1:0]          if_rdata_q;
  logic [DATA_W-1:0]          mem_rdata_q;
  logic [ADDR_W+BEAT_W-1:0]   ram_addr_q;
  logic [ADDR_W+BEAT_W-1:0]   busy_addr;
  logic                       grant_mem;
  logic                       grant_if;
  logic                       last_beat;

  assign busy_addr = {lat_addr_q, beat_q};
  assign last_beat = (beat_q == BEAT_W'(BEATS - 1));
  // Read slices enter at the LSB, so after BEATS shifts the first slice sits at the MSB.
  assign buf_d     = {buf_q[DATA_W-RAM_W-1:0], ram_rdata};

  // Arbitration is only live in IDLE and never while reset is asserted.
  always_comb begin
    grant_mem = 1'b0;
    grant_if  = 1'b0;
    if (reset && state_q == StIdle) begin
      if (FAIR == 0) begin
        if (mem_req) begin
          grant_mem = 1'b1;
        end else if (if_req) begin
          grant_if = 1'b1;
        end
      end else begin
        if (mem_req && if_req) begin
          grant_if  = last_mem_q;
          grant_mem = !last_mem_q;
        end else begin
          grant_mem = mem_req;
          grant_if  = if_req;
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (grant_mem || grant_if) state_d = StBusy;
      StBusy:  if (last_beat) state_d = StResp;
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      beat_q      <= '0;
      lat_addr_q  <= '0;
      lat_we_q    <= 1'b0;
      lat_wdata_q <= '0;
      lat_mem_q   <= 1'b0;
      last_mem_q  <= 1'b1;
      buf_q       <= '0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
      ram_addr_q  <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        StIdle: begin
          if (grant_mem || grant_if) begin
            lat_addr_q  <= grant_mem ? mem_addr : if_addr;
            lat_we_q    <= grant_mem & mem_we;
            lat_wdata_q <= grant_mem ? mem_wdata : '0;
            lat_mem_q   <= grant_mem;
            last_mem_q  <= grant_mem;
            beat_q      <= '0;
          end
        end
        StBusy: begin
          beat_q      <= beat_q + BEAT_W'(1);
          ram_addr_q  <= busy_addr;
          // Write data shifts left so the current slice is always at the MSB.
          lat_wdata_q <= lat_wdata_q << RAM_W;
          if (!lat_we_q) begin
            buf_q <= buf_d;
            if (last_beat) begin
              if (lat_mem_q) begin
                mem_rdata_q <= buf_d;
              end else begin
                if_rdata_q <= buf_d;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign if_ack    = grant_if;
  assign mem_ack   = grant_mem;
  assign if_valid  = (state_q == StResp) && !lat_mem_q;
  assign mem_valid = (state_q == StResp) && lat_mem_q;
  assign if_rdata  = if_rdata_q;
  assign mem_rdata = mem_rdata_q;
  // Outside BUSY the RAM address parks on the last beat driven.
  assign ram_addr  = (state_q == StBusy) ? busy_addr : ram_addr_q;
  assign ram_we    = (state_q == StBusy) && lat_we_q;
  assign ram_wdata = (state_q == StBusy) ? lat_wdata_q[DATA_W-1 -: RAM_W] : '0;

endmodule

// File: tb/tb_mem_ctrl_arb.sv
// Bench for mem_ctrl_arb: fixed-priority and round-robin 32/16 instances share stimulus,
// a 64/16 instance covers four-beat transfers. Valid pulses are scored against queued expectations.
module tb_mem_ctrl_arb;

  typedef struct packed {
    logic        is_mem;
    logic [63:0] data;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        if_req, mem_req, mem_we;
  logic [16:0] if_addr, mem_addr;
  logic [31:0] mem_wdata;

  logic        a_if_ack, a_if_valid, a_mem_ack, a_mem_valid, a_ram_we;
  logic [31:0] a_if_rdata, a_mem_rdata;
  logic [17:0] a_ram_addr;
  logic [15:0] a_ram_wdata, a_ram_rdata;
  logic        b_if_ack, b_if_valid, b_mem_ack, b_mem_valid, b_ram_we;
  logic [31:0] b_if_rdata, b_mem_rdata;
  logic [17:0] b_ram_addr;
  logic [15:0] b_ram_wdata, b_ram_rdata;

  logic        c_mem_req, c_mem_we;
  logic [16:0] c_mem_addr;
  logic [63:0] c_mem_wdata;
  logic        c_if_ack, c_if_valid, c_mem_ack, c_mem_valid, c_ram_we;
  logic [63:0] c_if_rdata, c_mem_rdata;
  logic [18:0] c_ram_addr;
  logic [15:0] c_ram_wdata, c_ram_rdata;

  logic [15:0] ram_a [0:63];
  logic [15:0] ram_b [0:63];
  logic [15:0] ram_c [0:63];
  logic [15:0] shadow [0:63];

  int          n_vec = 0;
  int          n_err = 0;
  logic        sb_on;
  logic [31:0] model_if_rd, model_mem_rd;
  exp_t        q_a[$];
  exp_t        q_b[$];
  logic [63:0] q_c[$];

  always #5 clock = ~clock;

  mem_ctrl_arb #(.DATA_W(32), .RAM_W(16), .ADDR_W(17), .BEAT_W(1), .FAIR(0)) u_dut_a (
    .clock(clock), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_ack(a_if_ack), .if_valid(a_if_valid),
    .if_rdata(a_if_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(a_mem_ack), .mem_valid(a_mem_valid), .mem_rdata(a_mem_rdata),
    .ram_addr(a_ram_addr), .ram_we(a_ram_we), .ram_wdata(a_ram_wdata), .ram_rdata(a_ram_rdata)
  );

  mem_ctrl_arb #(.DATA_W(32), .RAM_W(16), .ADDR_W(17), .BEAT_W(1), .FAIR(1)) u_dut_b (
    .clock(clock), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_ack(b_if_ack), .if_valid(b_if_valid),
    .if_rdata(b_if_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(b_mem_ack), .mem_valid(b_mem_valid), .mem_rdata(b_mem_rdata),
    .ram_addr(b_ram_addr), .ram_we(b_ram_we), .ram_wdata(b_ram_wdata), .ram_rdata(b_ram_rdata)
  );

  mem_ctrl_arb #(.DATA_W(64), .RAM_W(16), .ADDR_W(17), .BEAT_W(2), .FAIR(0)) u_dut_c (
    .clock(clock), .reset(reset),
    .if_req(1'b0), .if_addr(17'd0), .if_ack(c_if_ack), .if_valid(c_if_valid),
    .if_rdata(c_if_rdata),
    .mem_req(c_mem_req), .mem_we(c_mem_we), .mem_addr(c_mem_addr), .mem_wdata(c_mem_wdata),
    .mem_ack(c_mem_ack), .mem_valid(c_mem_valid), .mem_rdata(c_mem_rdata),
    .ram_addr(c_ram_addr), .ram_we(c_ram_we), .ram_wdata(c_ram_wdata), .ram_rdata(c_ram_rdata)
  );

  assign a_ram_rdata = ram_a[a_ram_addr[5:0]];
  assign b_ram_rdata = ram_b[b_ram_addr[5:0]];
  assign c_ram_rdata = ram_c[c_ram_addr[5:0]];

  always @(posedge clock) begin
    if (a_ram_we) ram_a[a_ram_addr[5:0]] <= a_ram_wdata;
    if (b_ram_we) ram_b[b_ram_addr[5:0]] <= b_ram_wdata;
    if (c_ram_we) ram_c[c_ram_addr[5:0]] <= c_ram_wdata;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rd_word(input logic [16:0] a);
    return {shadow[{a[4:0], 1'b0}], shadow[{a[4:0], 1'b1}]};
  endfunction

  always @(negedge clock) begin
    if (reset && sb_on && (a_if_valid || a_mem_valid)) begin
      exp_t e;
      if (q_a.size() == 0) begin
        check("a_unexpected_valid", 64'({a_mem_valid, a_if_valid}), 64'd0);
      end else begin
        e = q_a.pop_front();
        check("a_valid_port", 64'({a_mem_valid, a_if_valid}), e.is_mem ? 64'd2 : 64'd1);
        check("a_rdata", e.is_mem ? 64'(a_mem_rdata) : 64'(a_if_rdata), e.data);
      end
    end
  end

  always @(negedge clock) begin
    if (reset && sb_on && (b_if_valid || b_mem_valid)) begin
      exp_t e;
      if (q_b.size() == 0) begin
        check("b_unexpected_valid", 64'({b_mem_valid, b_if_valid}), 64'd0);
      end else begin
        e = q_b.pop_front();
        check("b_valid_port", 64'({b_mem_valid, b_if_valid}), e.is_mem ? 64'd2 : 64'd1);
        check("b_rdata", e.is_mem ? 64'(b_mem_rdata) : 64'(b_if_rdata), e.data);
      end
    end
  end

  always @(negedge clock) begin
    if (reset && (c_if_valid || c_mem_valid)) begin
      if (q_c.size() == 0 || c_if_valid) begin
        check("c_unexpected_valid", 64'({c_mem_valid, c_if_valid}), 64'd2);
      end else begin
        check("c_mem_rdata", c_mem_rdata, q_c.pop_front());
      end
    end
  end

  // Drive one transaction on the shared A/B inputs and queue its expected result.
  task automatic issue(input logic is_mem, input logic we, input logic [16:0] addr,
                       input logic [31:0] wdata, input logic push);
    logic        found;
    logic [31:0] data;
    exp_t        e;
    found = 1'b0;
    @(posedge clock);
    #1;
    if (is_mem) begin
      mem_req = 1'b1; mem_we = we; mem_addr = addr; mem_wdata = wdata;
    end else begin
      if_req = 1'b1; if_addr = addr;
    end
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clock);
      found = is_mem ? a_mem_ack : a_if_ack;
    end
    check("a_ack_seen", 64'(found), 64'd1);
    check("b_ack_seen", 64'(is_mem ? b_mem_ack : b_if_ack), 64'd1);
    if (push) begin
      if (is_mem && we) begin
        shadow[{addr[4:0], 1'b0}] = wdata[31:16];
        shadow[{addr[4:0], 1'b1}] = wdata[15:0];
        e.data = 64'(model_mem_rd);
      end else begin
        data = rd_word(addr);
        if (is_mem) model_mem_rd = data;
        else model_if_rd = data;
        e.data = 64'(data);
      end
      e.is_mem = is_mem;
      q_a.push_back(e);
      q_b.push_back(e);
    end
    @(posedge clock);
    #1;
    mem_req = 1'b0;
    if_req  = 1'b0;
  endtask

  initial begin
    logic       found;
    int         n_mem_ack, n_if_ack;
    logic       b_last_mem;
    logic [0:0] seq[$];

    for (int i = 0; i < 64; i++) begin
      ram_a[i] <= 16'(i * 257);
      ram_b[i] <= 16'(i * 257);
      ram_c[i] <= 16'(i * 257);
      shadow[i] = 16'(i * 257);
    end
    ram_a[32] <= 16'hDEAD; ram_b[32] <= 16'hDEAD; shadow[32] = 16'hDEAD;
    ram_a[33] <= 16'hBEEF; ram_b[33] <= 16'hBEEF; shadow[33] = 16'hBEEF;
    ram_c[4] <= 16'hA1B2; ram_c[5] <= 16'hC3D4; ram_c[6] <= 16'hE5F6; ram_c[7] <= 16'h0718;
    reset = 1'b0;
    sb_on = 1'b1;
    if_req = 1'b0; if_addr = '0;
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = '0; mem_wdata = '0;
    c_mem_req = 1'b0; c_mem_we = 1'b0; c_mem_addr = '0; c_mem_wdata = '0;
    model_if_rd = '0;
    model_mem_rd = '0;

    // Reset state, with a request pending that must not be acknowledged.
    repeat (2) @(negedge clock);
    check("rst_mem_ack", 64'(a_mem_ack), 64'd0);
    check("rst_ram_addr", 64'(a_ram_addr), 64'd0);
    check("rst_ram_we", 64'(a_ram_we), 64'd0);
    check("rst_if_rdata", 64'(a_if_rdata), 64'd0);
    check("rst_valids", 64'({a_mem_valid, a_if_valid}), 64'd0);
    mem_req = 1'b0;
    @(negedge clock);
    reset = 1'b1;

    // Fetch read from word 0x10: RAM 0x20 then 0x21, valid three cycles after ack.
    issue(1'b0, 1'b0, 17'h10, 32'h0, 1'b1);
    @(negedge clock);
    check("fetch_addr0", 64'(a_ram_addr), 64'h20);
    check("fetch_we0", 64'(a_ram_we), 64'd0);
    @(negedge clock);
    check("fetch_addr1", 64'(a_ram_addr), 64'h21);
    @(negedge clock);
    check("fetch_valid", 64'(a_if_valid), 64'd1);
    check("fetch_rdata", 64'(a_if_rdata), 64'hDEADBEEF);
    @(negedge clock);
    check("fetch_valid_pulse", 64'(a_if_valid), 64'd0);
    check("fetch_rdata_hold", 64'(a_if_rdata), 64'hDEADBEEF);

    // Data write 0x12345678 to word 3.
    issue(1'b1, 1'b1, 17'd3, 32'h12345678, 1'b1);
    @(negedge clock);
    check("wr_beat0", 64'({a_ram_we, a_ram_addr, a_ram_wdata}), 64'({1'b1, 18'd6, 16'h1234}));
    @(negedge clock);
    check("wr_beat1", 64'({a_ram_we, a_ram_addr, a_ram_wdata}), 64'({1'b1, 18'd7, 16'h5678}));
    @(negedge clock);
    check("wr_valid", 64'(a_mem_valid), 64'd1);
    check("wr_resp_we", 64'(a_ram_we), 64'd0);
    check("wr_mem_rdata", 64'(a_mem_rdata), 64'(model_mem_rd));
    @(negedge clock);
    check("wr_ram6", 64'(ram_a[6]), 64'(shadow[6]));
    check("wr_ram7", 64'(ram_a[7]), 64'(shadow[7]));
    check("wr_ramb7", 64'(ram_b[7]), 64'(shadow[7]));

    // Reset during the second beat of a write to word 5: only beat 0 lands.
    issue(1'b1, 1'b1, 17'd5, 32'hAAAABBBB, 1'b0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    mem_req = 1'b1;
    #1;
    check("mid_rst_ram", 64'({a_ram_we, a_ram_addr, a_ram_wdata}), 64'd0);
    check("mid_rst_rdata", 64'({a_if_rdata, a_mem_rdata}), 64'd0);
    check("mid_rst_ack_valid", 64'({a_if_ack, a_mem_ack, a_if_valid, a_mem_valid}), 64'd0);
    mem_req = 1'b0;
    model_if_rd = '0;
    model_mem_rd = '0;
    shadow[10] = 16'hAAAA;
    @(negedge clock);
    reset = 1'b1;
    repeat (5) @(negedge clock);
    check("mid_rst_ram10", 64'(ram_a[10]), 64'(shadow[10]));
    check("mid_rst_ram11", 64'(ram_a[11]), 64'(shadow[11]));

    // Fixed priority: both held, memory wins every grant until released.
    sb_on = 1'b0;
    n_mem_ack = 0;
    n_if_ack = 0;
    @(posedge clock);
    #1;
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 17'd3;
    if_req = 1'b1; if_addr = 17'h10;
    for (int i = 0; i < 16; i++) begin
      @(negedge clock);
      if (a_mem_ack) n_mem_ack++;
      if (a_if_ack) n_if_ack++;
    end
    check("fix_mem_grants", 64'(n_mem_ack), 64'd4);
    check("fix_if_grants", 64'(n_if_ack), 64'd0);
    @(posedge clock);
    #1;
    mem_req = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 6 && !found; i++) begin
      @(negedge clock);
      found = a_if_ack;
    end
    check("fix_if_after_release", 64'(found), 64'd1);
    @(posedge clock);
    #1;
    if_req = 1'b0;
    repeat (10) @(negedge clock);

    // Round-robin: memory first, then both held; grants alternate.
    b_last_mem = 1'b0;
    @(posedge clock);
    #1;
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 17'd3;
    for (int i = 0; i < 16; i++) begin
      @(negedge clock);
      if (b_mem_ack) seq.push_back(1'b1);
      if (b_if_ack) seq.push_back(1'b0);
      if (b_if_valid || b_mem_valid) begin
        check("rr_valid_port", 64'({b_mem_valid, b_if_valid}), b_last_mem ? 64'd2 : 64'd1);
        check("rr_rdata", b_last_mem ? 64'(b_mem_rdata) : 64'(b_if_rdata),
              b_last_mem ? 64'(rd_word(17'd3)) : 64'(rd_word(17'h10)));
      end
      if (b_mem_ack) b_last_mem = 1'b1;
      if (b_if_ack) b_last_mem = 1'b0;
      @(posedge clock);
      #1;
      if_req = 1'b1;
    end
    mem_req = 1'b0;
    if_req = 1'b0;
    check("rr_grant_count", 64'(seq.size()), 64'd4);
    for (int k = 0; k < seq.size() && k < 4; k++) begin
      check("rr_grant_order", 64'(seq[k]), (k % 2 == 0) ? 64'd1 : 64'd0);
    end
    repeat (10) @(negedge clock);
    sb_on = 1'b1;

    // Four-beat read on the 64-bit instance from word 1.
    @(posedge clock);
    #1;
    c_mem_req = 1'b1; c_mem_we = 1'b0; c_mem_addr = 17'd1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clock);
      found = c_mem_ack;
    end
    check("c_ack_seen", 64'(found), 64'd1);
    q_c.push_back(64'hA1B2_C3D4_E5F6_0718);
    @(posedge clock);
    #1;
    c_mem_req = 1'b0;
    for (int j = 0; j < 4; j++) begin
      @(negedge clock);
      check("c_ram_addr", 64'(c_ram_addr), 64'(4 + j));
    end
    @(negedge clock);
    check("c_valid", 64'(c_mem_valid), 64'd1);
    repeat (4) @(negedge clock);

    check("a_queue_drained", 64'(q_a.size()), 64'd0);
    check("b_queue_drained", 64'(q_b.size()), 64'd0);
    check("c_queue_drained", 64'(q_c.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
